// File: rtl/lines_feeder_pkg.sv
// rtl/lines_feeder_pkg.sv - shared types and constants for the line-pair UART feeder
//
// Purpose: FSM state encoding, ASCII constants and the WAIT_BUSY timeout
// used by lines_to_uart_feeder.
// Ports: none (package).
package lines_feeder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND      = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_IDLE = 3'd3,
        ST_DONE      = 3'd4
    } feeder_state_e;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    // Cycles to wait in WAIT_BUSY for the transmitter to drop idle.
    localparam int BUSY_TIMEOUT = 4;

endpackage

// File: rtl/lines_to_uart_feeder.sv
// rtl/lines_to_uart_feeder.sv - serialises two ASCII lines byte by byte into a UART transmitter
//
// Purpose: accepts a line pair on a valid/ready handshake, holds it, and
// presents one character at a time to a UART transmitter, pacing itself on
// the transmitter's idle flag. Optional CR/LF terminator when the macro
// LINES_FEEDER_CRLF_EN is defined.
// Ports:
//   i_clk_20mhz    - system clock, rising edge
//   i_rstn_20mhz   - synchronous active-low reset
//   i_line1/2      - PARM_LINE_CHARS characters each, character 0 in the MSB byte
//   i_lines_valid  - producer offers a line pair
//   o_lines_ready  - feeder can accept a line pair (IDLE only)
//   o_tx_data      - registered character for the transmitter
//   o_tx_go        - one-cycle transmit request
//   i_tx_idle      - transmitter can accept a byte
//   o_busy         - transfer in progress
module lines_to_uart_feeder
    import lines_feeder_pkg::*;
#(
    parameter int PARM_LINE_CHARS = 16
) (
    input  logic                           i_clk_20mhz,
    input  logic                           i_rstn_20mhz,
    input  logic [PARM_LINE_CHARS*8-1:0]   i_line1,
    input  logic [PARM_LINE_CHARS*8-1:0]   i_line2,
    input  logic                           i_lines_valid,
    output logic                           o_lines_ready,
    output logic [7:0]                     o_tx_data,
    output logic                           o_tx_go,
    input  logic                           i_tx_idle,
    output logic                           o_busy
);

    localparam int N      = PARM_LINE_CHARS;
    localparam int HOLD_W = 2 * N * 8;
    localparam int IDX_W  = $clog2(2 * N + 2);
`ifdef LINES_FEEDER_CRLF_EN
    localparam int TOTAL  = 2 * N + 2;
`else
    localparam int TOTAL  = 2 * N;
`endif

    feeder_state_e     state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [2:0]        tmo_q, tmo_d;
    // Low for the reset edges so ready only rises on the first edge after release.
    logic              rst_done_q, rst_done_d;

    logic [IDX_W-1:0]  next_idx;
    logic [7:0]        next_byte;

    assign next_idx = idx_q + IDX_W'(1);

    // Byte for the next index: line 1 then line 2 (both MSB-first), then terminator.
    always_comb begin
        next_byte = ASCII_SPACE;
        for (int i = 0; i < 2 * N; i++) begin
            if (next_idx == IDX_W'(i)) begin
                next_byte = hold_q[HOLD_W-8-8*i +: 8];
            end
        end
`ifdef LINES_FEEDER_CRLF_EN
        if (next_idx == IDX_W'(2 * N)) begin
            next_byte = ASCII_CR;
        end
        if (next_idx == IDX_W'(2 * N + 1)) begin
            next_byte = ASCII_LF;
        end
`endif
    end

    // State register
    always_ff @(posedge i_clk_20mhz) begin
        if (!i_rstn_20mhz) begin
            state_q    <= ST_IDLE;
            hold_q     <= {(2 * N){ASCII_SPACE}};
            idx_q      <= '0;
            tx_data_q  <= 8'h00;
            tmo_q      <= '0;
            rst_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            idx_q      <= idx_d;
            tx_data_q  <= tx_data_d;
            tmo_q      <= tmo_d;
            rst_done_q <= rst_done_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        idx_d      = idx_q;
        tx_data_d  = tx_data_q;
        tmo_d      = tmo_q;
        rst_done_d = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (i_lines_valid && rst_done_q) begin
                    hold_d    = {i_line1, i_line2};
                    idx_d     = '0;
                    // Preload character 0 so go can fire in the very next cycle.
                    tx_data_d = i_line1[N*8-1 -: 8];
                    state_d   = ST_SEND;
                end
            end
            ST_SEND: begin
                if (i_tx_idle) begin
                    tmo_d   = '0;
                    state_d = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                // A transmitter that never reports busy is treated as done after the timeout.
                if (!i_tx_idle || tmo_q == 3'(BUSY_TIMEOUT - 1)) begin
                    state_d = ST_WAIT_IDLE;
                end else begin
                    tmo_d = tmo_q + 3'd1;
                end
            end
            ST_WAIT_IDLE: begin
                if (i_tx_idle) begin
                    idx_d = next_idx;
                    if (idx_q == IDX_W'(TOTAL - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        tx_data_d = next_byte;
                        state_d   = ST_SEND;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        o_tx_go       = (state_q == ST_SEND) && i_tx_idle;
        o_lines_ready = (state_q == ST_IDLE) && rst_done_q;
        o_busy        = (state_q != ST_IDLE);
        o_tx_data     = tx_data_q;
    end

endmodule
